ps2_scan_receiver: RTL and testbench

//  Front-end PS/2 keyboard receiver. It deserialises 11-bit device-to-host frames
//  (start, 8 data LSB-first, odd parity, stop) from the raw PS2 clock/data pins.
//  It folds the F0 break prefix into a make/break flag and delivers one scan code per key event.
//  It feeds the LCD/character path: consumers edge-detect PS2_code_ready and read PS2_code/PS2_make_code.

---
 rtl/ps2_pkg.sv | 7 +
 rtl/ps2_clock_filter.sv | 46 ++++
 rtl/ps2_scan_receiver.sv | 113 +++++++++++
 tb/tb_ps2_scan_receiver.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard scan-code receiver.
package ps2_pkg;
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} ps2_rx_state_t;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
endpackage

// File: rtl/ps2_clock_filter.sv
// Synchronises the raw PS/2 pins and debounces the PS/2 clock; emits a
// single-cycle fall strobe on each filtered falling edge.
module ps2_clock_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic CLOCK_50_I,
    input  logic resetn,
    input  logic PS2_CLOCK_I,
    input  logic PS2_DATA_I,
    output logic data_sync,
    output logic fall
);
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_meta;
    logic [1:0]    dat_meta;
    logic [FW-1:0] flt_cnt;
    logic          filt_clk;
    logic          filt_prev;

    // Sync flops reset to 1 to match an idle bus, so release never fakes an edge.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            clk_meta  <= 2'b11;
            dat_meta  <= 2'b11;
            flt_cnt   <= '0;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            clk_meta  <= {clk_meta[0], PS2_CLOCK_I};
            dat_meta  <= {dat_meta[0], PS2_DATA_I};
            filt_prev <= filt_clk;
            if (clk_meta[1] == filt_clk) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_meta[1];
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign data_sync = dat_meta[1];
    assign fall      = filt_prev & ~filt_clk;
endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver: deserialises frames, strips E0/F0
// prefixes and delivers one scan code plus make/break flag per key event.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic       PS2_CLOCK_I,
    input  logic       PS2_DATA_I,
    output logic [7:0] PS2_code,
    output logic       PS2_code_ready,
    output logic       PS2_make_code,
    output logic       PS2_frame_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    ps2_rx_state_t state, state_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic          break_pending;
    logic [TW-1:0] tcnt;
    logic          data_sync;
    logic          fall;
    logic          timeout;
    logic          frame_ok;

    ps2_clock_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .PS2_CLOCK_I(PS2_CLOCK_I),
        .PS2_DATA_I (PS2_DATA_I),
        .data_sync  (data_sync),
        .fall       (fall)
    );

    // Stop bit is the live data sample in the S_STOP fall cycle.
    assign frame_ok = (^{shift_reg, parity_bit}) & data_sync;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // A fall always takes priority over an expiring timeout.
    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        if (fall) begin
            case (state)
                S_IDLE:   if (!data_sync) state_nxt = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
                S_PARITY: state_nxt = S_STOP;
                S_STOP:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end else if (state != S_IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout   = 1'b1;
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            bit_cnt         <= '0;
            shift_reg       <= '0;
            parity_bit      <= 1'b0;
            break_pending   <= 1'b0;
            tcnt            <= '0;
            PS2_code        <= '0;
            PS2_code_ready  <= 1'b0;
            PS2_make_code   <= 1'b0;
            PS2_frame_error <= 1'b0;
        end else begin
            PS2_code_ready  <= 1'b0;
            PS2_frame_error <= 1'b0;

            if (fall || state == S_IDLE || timeout) tcnt <= '0;
            else                                    tcnt <= tcnt + 1'b1;

            if (timeout) begin
                bit_cnt         <= '0;
                PS2_frame_error <= 1'b1;
            end else if (fall) begin
                case (state)
                    S_IDLE:   if (!data_sync) bit_cnt <= '0;
                    S_DATA: begin
                        shift_reg <= {data_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    S_PARITY: parity_bit <= data_sync;
                    S_STOP: begin
                        if (!frame_ok) begin
                            PS2_frame_error <= 1'b1;
                            break_pending   <= 1'b0;
                        end else if (shift_reg == PS2_BREAK_CODE) begin
                            break_pending <= 1'b1;
                        end else if (shift_reg != PS2_EXT_CODE) begin
                            PS2_code       <= shift_reg;
                            PS2_make_code  <= ~break_pending;
                            break_pending  <= 1'b0;
                            PS2_code_ready <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: bit-bangs PS/2 frames and checks
// delivered codes, make/break flags, pulse counts, timeout and reset.
`timescale 1ns/1ps
module tb_ps2_scan_receiver;
    import ps2_pkg::*;

    localparam int HALF = 50;
    localparam int TO   = 500;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] PS2_code;
    logic       PS2_code_ready;
    logic       PS2_make_code;
    logic       PS2_frame_error;

    int total = 0;
    int bad   = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;
    int r0, e0;

    always #10 clk = ~clk;

    ps2_scan_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50_I     (clk),
        .resetn         (resetn),
        .PS2_CLOCK_I    (ps2_clk),
        .PS2_DATA_I     (ps2_dat),
        .PS2_code       (PS2_code),
        .PS2_code_ready (PS2_code_ready),
        .PS2_make_code  (PS2_make_code),
        .PS2_frame_error(PS2_frame_error)
    );

    always @(negedge clk) begin
        if (PS2_code_ready)  rdy_cnt++;
        if (PS2_frame_error) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Device drives data while clock is high, then pulses clock low.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_dat = b;
        if (glitch) begin
            tick(20);
            ps2_clk = 1'b0;
            tick(3);
            ps2_clk = 1'b1;
            tick(HALF - 23);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit glitch);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i], glitch && (i == 3 || i == 6));
        ps2_dat = 1'b1;
        tick(HALF);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11, 1'b0);
    endtask

    initial begin
        resetn  = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        tick(5);
        check("rst_code",  32'(PS2_code), 32'h0);
        check("rst_ready", 32'(PS2_code_ready), 32'h0);
        check("rst_make",  32'(PS2_make_code), 32'h0);
        check("rst_err",   32'(PS2_frame_error), 32'h0);
        check("rst_state", 32'(dut.state), 32'(S_IDLE));
        resetn = 1'b1;
        tick(20);

        // single make code
        r0 = rdy_cnt; e0 = err_cnt;
        good(8'h1C);
        check("t1_rdy",  32'(rdy_cnt), 32'(r0 + 1));
        check("t1_err",  32'(err_cnt), 32'(e0));
        check("t1_code", 32'(PS2_code), 32'h1C);
        check("t1_make", 32'(PS2_make_code), 32'h1);

        // break sequence then make again
        r0 = rdy_cnt;
        good(8'hF0);
        check("t2_f0_rdy", 32'(rdy_cnt), 32'(r0));
        good(8'h1C);
        check("t2_brk_rdy",  32'(rdy_cnt), 32'(r0 + 1));
        check("t2_brk_code", 32'(PS2_code), 32'h1C);
        check("t2_brk_make", 32'(PS2_make_code), 32'h0);
        good(8'h1C);
        check("t2_mk_rdy",  32'(rdy_cnt), 32'(r0 + 2));
        check("t2_mk_make", 32'(PS2_make_code), 32'h1);

        // parity error, then error clears a pending break, then stop error
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
        check("t3_par_err",  32'(err_cnt), 32'(e0 + 1));
        check("t3_par_rdy",  32'(rdy_cnt), 32'(r0));
        check("t3_par_code", 32'(PS2_code), 32'h1C);
        good(8'hF0);
        send_frame(8'h33, 1'b1, 1'b0, 11, 1'b0);
        check("t3_clr_code", 32'(PS2_code), 32'h1C);
        good(8'h21);
        check("t3_clr_code2", 32'(PS2_code), 32'h21);
        check("t3_clr_make",  32'(PS2_make_code), 32'h1);
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(8'h44, 1'b0, 1'b1, 11, 1'b0);
        check("t3_stop_err",  32'(err_cnt), 32'(e0 + 1));
        check("t3_stop_code", 32'(PS2_code), 32'h21);

        // timeout mid-frame keeps pending break
        good(8'hF0);
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 6, 1'b0);
        check("t4_pre_err", 32'(err_cnt), 32'(e0));
        tick(TO + 200);
        check("t4_to_err",   32'(err_cnt), 32'(e0 + 1));
        check("t4_to_rdy",   32'(rdy_cnt), 32'(r0));
        check("t4_to_state", 32'(dut.state), 32'(S_IDLE));
        good(8'h32);
        check("t4_code", 32'(PS2_code), 32'h32);
        check("t4_make", 32'(PS2_make_code), 32'h0);
        check("t4_rdy",  32'(rdy_cnt), 32'(r0 + 1));
        check("t4_err",  32'(err_cnt), 32'(e0 + 1));

        // short clock glitches are filtered out
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(8'h4D, 1'b0, 1'b0, 11, 1'b1);
        check("t5_code", 32'(PS2_code), 32'h4D);
        check("t5_make", 32'(PS2_make_code), 32'h1);
        check("t5_rdy",  32'(rdy_cnt), 32'(r0 + 1));
        check("t5_err",  32'(err_cnt), 32'(e0));

        // extended break, then reset mid-frame
        r0 = rdy_cnt; e0 = err_cnt;
        good(8'hE0);
        good(8'hF0);
        check("t6_pre_rdy", 32'(rdy_cnt), 32'(r0));
        good(8'h75);
        check("t6_rdy",  32'(rdy_cnt), 32'(r0 + 1));
        check("t6_code", 32'(PS2_code), 32'h75);
        check("t6_make", 32'(PS2_make_code), 32'h0);
        check("t6_err",  32'(err_cnt), 32'(e0));
        send_frame(8'h5A, 1'b0, 1'b0, 4, 1'b0);
        resetn = 1'b0;
        tick(3);
        check("t6_rst_code",  32'(PS2_code), 32'h0);
        check("t6_rst_make",  32'(PS2_make_code), 32'h0);
        check("t6_rst_state", 32'(dut.state), 32'(S_IDLE));
        r0 = rdy_cnt; e0 = err_cnt;
        resetn = 1'b1;
        tick(TO + 200);
        check("t6_post_rdy", 32'(rdy_cnt), 32'(r0));
        check("t6_post_err", 32'(err_cnt), 32'(e0));
        good(8'h29);
        check("t6_after_code", 32'(PS2_code), 32'h29);
        check("t6_after_make", 32'(PS2_make_code), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
